// File: rtl/triangle_reg_interface.sv
`default_nettype none
// ============================================================================
// Module   : triangle_reg_interface
// Purpose  : CPU register front end for the APU triangle channel; holds shadow
//            load data and turns CPU writes into cpu_clk_en-aligned strobes.
// Revision : 1.0 - initial release
// ============================================================================
module triangle_reg_interface #(
  parameter logic [4:0] TRI_BASE    = 5'h08,
  parameter logic [4:0] STATUS_ADDR = 5'h15
) (
  input  logic        clk,
  input  logic        rst_l,
  input  logic        cpu_clk_en,
  input  logic        reg_we,
  input  logic [4:0]  reg_addr,
  input  logic [7:0]  reg_wdata,
  output logic        control_flag,
  output logic [6:0]  linear_load_data,
  output logic [10:0] timer_load_data,
  output logic [4:0]  length_load_data,
  output logic        linear_load,
  output logic        timer_load,
  output logic        length_load,
  output logic        disable_l
);

  localparam logic [4:0] ADDR_LINEAR = TRI_BASE;
  localparam logic [4:0] ADDR_TLO    = TRI_BASE + 5'd2;
  localparam logic [4:0] ADDR_THI    = TRI_BASE + 5'd3;

  logic       ctrl_q,     ctrl_d;
  logic [6:0] lin_q,      lin_d;
  logic [7:0] tlo_q,      tlo_d;
  logic [2:0] thi_q,      thi_d;
  logic [4:0] len_q,      len_d;
  logic       dis_q,      dis_d;
  logic       lin_pend_q, lin_pend_d;
  logic       tim_pend_q, tim_pend_d;
  logic       len_pend_q, len_pend_d;

  logic w_wr_linear, w_wr_tlo, w_wr_thi, w_wr_status;

  assign w_wr_linear = reg_we && (reg_addr == ADDR_LINEAR);
  assign w_wr_tlo    = reg_we && (reg_addr == ADDR_TLO);
  assign w_wr_thi    = reg_we && (reg_addr == ADDR_THI);
  assign w_wr_status = reg_we && (reg_addr == STATUS_ADDR);

  always_comb begin
    ctrl_d = ctrl_q;
    lin_d  = lin_q;
    tlo_d  = tlo_q;
    thi_d  = thi_q;
    len_d  = len_q;
    dis_d  = dis_q;

    if (w_wr_linear) begin
      ctrl_d = reg_wdata[7];
      lin_d  = reg_wdata[6:0];
    end
    if (w_wr_tlo) begin
      tlo_d = reg_wdata;
    end
    if (w_wr_thi) begin
      thi_d = reg_wdata[2:0];
      len_d = reg_wdata[7:3];
    end
    if (w_wr_status) begin
      dis_d = reg_wdata[2];
    end

    // A pending flag drops on an enable edge unless a new write re-arms it on
    // that same edge. Length only arms if the channel was already enabled.
    lin_pend_d = (lin_pend_q & ~cpu_clk_en) | w_wr_thi;
    tim_pend_d = (tim_pend_q & ~cpu_clk_en) | w_wr_tlo | w_wr_thi;
    len_pend_d = (len_pend_q & ~cpu_clk_en) | (w_wr_thi & dis_q);
    if (w_wr_status && !reg_wdata[2]) begin
      len_pend_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      ctrl_q     <= 1'b0;
      lin_q      <= 7'd0;
      tlo_q      <= 8'd0;
      thi_q      <= 3'd0;
      len_q      <= 5'd0;
      dis_q      <= 1'b0;
      lin_pend_q <= 1'b0;
      tim_pend_q <= 1'b0;
      len_pend_q <= 1'b0;
    end else begin
      ctrl_q     <= ctrl_d;
      lin_q      <= lin_d;
      tlo_q      <= tlo_d;
      thi_q      <= thi_d;
      len_q      <= len_d;
      dis_q      <= dis_d;
      lin_pend_q <= lin_pend_d;
      tim_pend_q <= tim_pend_d;
      len_pend_q <= len_pend_d;
    end
  end

  assign control_flag     = ctrl_q;
  assign linear_load_data = lin_q;
  assign timer_load_data  = {thi_q, tlo_q};
  assign length_load_data = len_q;
  assign disable_l        = dis_q;

  assign linear_load = lin_pend_q & cpu_clk_en;
  assign timer_load  = tim_pend_q & cpu_clk_en;
  assign length_load = len_pend_q & cpu_clk_en & dis_q;

endmodule
`default_nettype wire

// File: doc/triangle_reg_interface.md
Name: triangle_reg_interface

Overview:
- CPU-facing register front end for the APU triangle channel.
- Decodes CPU writes to the triangle registers ($4008, $400A, $400B) and the channel enable bit in $4015.
- Holds shadow copies of all load data and produces the control flag, load strobes and disable_l that drive triangle_channel.
- Write strobes arrive on any clk cycle. Each load strobe is held pending and delivered as a single pulse on the next cpu_clk_en cycle, so the channel's clock-enabled registers sample it exactly once.

Parameters:
- TRI_BASE, 5'h08: address offset of $4008 within the $4000-$401F window. Triangle registers are TRI_BASE+0, +2 and +3.
- STATUS_ADDR, 5'h15: address offset of $4015.

Ports:
- clk  input  1  system clock
- rst_l  input  1  asynchronous active-low reset
- cpu_clk_en  input  1  CPU-rate clock enable, shared with triangle_channel
- reg_we  input  1  one-clk write strobe from the CPU bus
- reg_addr  input  5  address offset (A4..A0 of $40xx)
- reg_wdata  input  8  write data
- control_flag  output  1  $4008 bit 7
- linear_load_data  output  7  $4008 bits 6:0
- timer_load_data  output  11  {$400B[2:0], $400A[7:0]}
- length_load_data  output  5  $400B bits 7:3, raw length-table index
- linear_load  output  1  one-cycle load strobe, qualified by cpu_clk_en
- timer_load  output  1  one-cycle load strobe, qualified by cpu_clk_en
- length_load  output  1  one-cycle load strobe, qualified by cpu_clk_en
- disable_l  output  1  $4015 bit 2; 0 = channel disabled

Behaviour:
Reset:
- Reset is asynchronous and active-low.
- While rst_l=0: all shadow registers are 0, control_flag=0, every data output is 0, disable_l=0, all pending flags are 0, and all strobes are 0.

Write decode (reg_we=1, sampled at posedge clk):
- TRI_BASE+0: control_flag <= wdata[7]; linear_load_data <= wdata[6:0]. No strobe.
- TRI_BASE+1 ($4009): ignored.
- TRI_BASE+2: timer_lo <= wdata. Sets timer_pend.
- TRI_BASE+3: timer_hi <= wdata[2:0]; length_load_data <= wdata[7:3]. Sets timer_pend and linear_pend. Sets length_pend only if disable_l=1 before the edge.
- STATUS_ADDR: disable_l <= wdata[2]. If wdata[2]=0, clears length_pend.
- Any other address: ignored, no state change.
- Shadow data updates at the write edge regardless of cpu_clk_en.

Strobes:
- linear_load = linear_pend & cpu_clk_en.
- timer_load = timer_pend & cpu_clk_en.
- length_load = length_pend & cpu_clk_en & disable_l.
- Strobes are combinational from registered pending flags; the data outputs are already stable when a strobe is high.

Pending flags:
- A flag clears at the posedge where cpu_clk_en=1.
- If a write that sets the same flag lands on that same edge, the set wins and the flag stays 1.
- Latency: a write on edge N yields its strobe during the first clk cycle after edge N with cpu_clk_en=1. A write on a cpu_clk_en cycle therefore strobes at the next enable, never the same one.

Merging:
- Multiple writes to the same register between enables produce one strobe carrying the last-written data.
- $400A then $400B between enables produce one timer_load with the combined 11-bit value.

Disable interactions:
- Writing $4015 bit2=0 and $400B on the same edge: $4015 wins, length_pend=0.
- Writing $4015 bit2=1 and $400B on the same edge: length_pend stays 0, because the enable is not yet in effect.
- disable_l=0 never suppresses linear_load or timer_load.

Reset mid-operation: pending flags are lost and no strobe is emitted after release.

Test Plan:
- Reset, then write $4015=0x04; then $400A=0x34, $400B=0xA9, cpu_clk_en every 3rd clk -> timer_load_data=0x134 and length_load_data=0x15. Exactly one cycle each of timer_load, linear_load and length_load, coincident with the first cpu_clk_en after the $400B write.
- Write $4008=0xFF then $4008=0x05 -> control_flag=0, linear_load_data=0x05, no strobes.
- Write $400A twice (0x11, then 0x22) between two enables -> single timer_load pulse with timer_load_data[7:0]=0x22.
- disable_l=0 (after reset), write $400B=0xF8 -> timer_load and linear_load pulse, length_load stays 0. Then write $4015=0x04 -> still no length_load.
- Write $400B on the same edge as cpu_clk_en=1 -> no strobe in that cycle; strobes appear at the next cpu_clk_en.
- $400B written with disable_l=1, then $4015=0x00 before any enable -> length_load never asserts, disable_l=0. Separately, assert rst_l=0 with pending flags set -> all outputs 0 asynchronously and no strobes after release.
